// File: rtl/nexys_starship_shooter_pkg.sv
// Shared definitions for the starship weapon controller and the monster slot FSMs:
// one-hot state encodings, slot indices and the aim-priority helper.
package nexys_starship_shooter_pkg;

  localparam int ST_W = 5;

  // Bit positions of the one-hot state vector
  localparam int IDX_IDLE  = 0;
  localparam int IDX_READY = 1;
  localparam int IDX_KILL  = 2;
  localparam int IDX_COOL  = 3;
  localparam int IDX_LOCK  = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 5'b00001,
    S_READY = 5'b00010,
    S_KILL  = 5'b00100,
    S_COOL  = 5'b01000,
    S_LOCK  = 5'b10000
  } state_t;

  localparam logic [1:0] SLOT_TOP    = 2'd0;
  localparam logic [1:0] SLOT_BOTTOM = 2'd1;
  localparam logic [1:0] SLOT_LEFT   = 2'd2;
  localparam logic [1:0] SLOT_RIGHT  = 2'd3;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = SLOT_TOP;
    if (v[0])      idx = SLOT_TOP;
    else if (v[1]) idx = SLOT_BOTTOM;
    else if (v[2]) idx = SLOT_LEFT;
    else if (v[3]) idx = SLOT_RIGHT;
    return idx;
  endfunction

endpackage

// File: rtl/nexys_starship_tick_counter.sv
// Loadable down-counter; done flags the enabled cycle that consumes the last count.
// Load takes priority over enable; the counter rests at zero once exhausted.
module nexys_starship_tick_counter #(
  parameter int W = 7
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                    count <= '0;
    else if (load)                 count <= load_val;
    else if (en && count != '0)    count <= count - 1'b1;
  end

  assign done = en && (count == W'(1));

endmodule

// File: rtl/nexys_starship_shooter.sv
// Player weapon controller: aim/fire, held kill request until slot ack, heat/lockout/cooldown.
// All outputs registered; every decision lands on the next Clk edge, no input-to-output paths.
module nexys_starship_shooter
  import nexys_starship_shooter_pkg::*;
#(
  parameter int COOL_TICKS    = 4,
  parameter int HEAT_PER_SHOT = 4,
  parameter int HEAT_MAX      = 15,
  parameter int KILL_TIMEOUT  = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic       timer_tick,
  input  logic [3:0] btn_aim,
  input  logic       btn_fire,
  input  logic [3:0] monster_present,
  output logic [3:0] monster_ctrl,
  output logic [1:0] aim_dir,
  output logic [3:0] heat,
  output logic [7:0] kills,
  output logic       q_Idle,
  output logic       q_Ready,
  output logic       q_Kill,
  output logic       q_Cool,
  output logic       q_Lock
);

  localparam int CNT_MAX = (KILL_TIMEOUT > COOL_TICKS) ? KILL_TIMEOUT : COOL_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state;
  logic [1:0]    target;
  logic [4:0]    heat_sum;
  logic          start, shot, over, hit, ack;
  logic          kill_en, kill_done, kill_exit, kill_load;
  logic          cool_en, cool_done, cool_load;
  logic [CW-1:0] kill_val, cool_val;

  assign start     = (state == S_IDLE) && play_flag;
  assign shot      = (state == S_READY) && btn_fire && !game_over;
  assign heat_sum  = {1'b0, heat} + 5'(HEAT_PER_SHOT);
  assign over      = heat_sum > 5'(HEAT_MAX);
  assign hit       = monster_present[aim_dir];
  assign ack       = !monster_present[target];
  assign kill_en   = (state == S_KILL) && !game_over;
  assign kill_exit = kill_en && (ack || kill_done);
  assign cool_en   = (state == S_COOL) && timer_tick && !game_over;
  assign kill_load = start || (shot && !over && hit);
  assign cool_load = start || (shot && !over) || kill_exit;
  assign kill_val  = start ? '0 : CW'(KILL_TIMEOUT);
  assign cool_val  = start ? '0 : CW'(COOL_TICKS);

  nexys_starship_tick_counter #(.W(CW)) u_cool_cnt (
    .Clk(Clk), .Reset(Reset), .load(cool_load), .load_val(cool_val),
    .en(cool_en), .done(cool_done)
  );

  nexys_starship_tick_counter #(.W(CW)) u_kill_cnt (
    .Clk(Clk), .Reset(Reset), .load(kill_load), .load_val(kill_val),
    .en(kill_en), .done(kill_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      monster_ctrl <= '0;
      aim_dir      <= '0;
      heat         <= '0;
      kills        <= '0;
      target       <= '0;
    end else if (game_over && state != S_IDLE) begin
      state        <= S_IDLE;
      monster_ctrl <= '0;
    end else begin
      if (state != S_IDLE) begin
        if (|btn_aim) aim_dir <= lowest_set(btn_aim);
        // Decay first; a shot on the same cycle overrides with its combined result
        if (timer_tick && heat != '0) heat <= heat - 4'd1;
      end
      case (state)
        S_IDLE: if (play_flag) begin
          state <= S_READY;
          heat  <= '0;
          kills <= '0;
        end
        S_READY: if (shot) begin
          if (over) begin
            state <= S_LOCK;
          end else begin
            heat <= timer_tick ? 4'(heat_sum - 5'd1) : heat_sum[3:0];
            if (hit) begin
              state        <= S_KILL;
              target       <= aim_dir;
              monster_ctrl <= 4'(1) << aim_dir;
            end else begin
              state <= S_COOL;
            end
          end
        end
        S_KILL: if (ack) begin
          monster_ctrl <= '0;
          if (kills != 8'hFF) kills <= kills + 8'd1;
          state <= S_COOL;
        end else if (kill_done) begin
          monster_ctrl <= '0;
          state        <= S_COOL;
        end
        S_COOL: if (cool_done) state <= S_READY;
        S_LOCK: if (heat == '0) state <= S_READY;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign q_Idle  = state[IDX_IDLE];
  assign q_Ready = state[IDX_READY];
  assign q_Kill  = state[IDX_KILL];
  assign q_Cool  = state[IDX_COOL];
  assign q_Lock  = state[IDX_LOCK];

endmodule

// File: tb/tb_nexys_starship_shooter.sv
// Bench for nexys_starship_shooter: table-driven cycle vectors through a scoreboard queue,
// plus hand sequences for kill timeout, async reset mid-KILL and the heat lockout.
module tb_nexys_starship_shooter;

  localparam logic [4:0] ST_I = 5'b00001, ST_R = 5'b00010, ST_K = 5'b00100,
                         ST_C = 5'b01000, ST_L = 5'b10000;

  logic       Clk = 1'b0, Reset = 1'b0;
  logic       play_flag = 1'b0, game_over = 1'b0, timer_tick = 1'b0, btn_fire = 1'b0;
  logic [3:0] btn_aim = '0, monster_present = '0;

  logic [3:0] ctrl_a, heat_a, ctrl_b, heat_b;
  logic [1:0] aim_a, aim_b;
  logic [7:0] kills_a, kills_b;
  logic       ia, ra, ka, ca, la, ib, rb, kb, cb, lb;

  always #5 Clk = ~Clk;

  nexys_starship_shooter dut_a (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .timer_tick(timer_tick), .btn_aim(btn_aim), .btn_fire(btn_fire),
    .monster_present(monster_present), .monster_ctrl(ctrl_a), .aim_dir(aim_a),
    .heat(heat_a), .kills(kills_a), .q_Idle(ia), .q_Ready(ra), .q_Kill(ka),
    .q_Cool(ca), .q_Lock(la)
  );

  // With COOL_TICKS == HEAT_PER_SHOT the cooldown decay cancels each shot's heat,
  // so the lockout path is reached on a second instance with a single-tick cooldown.
  nexys_starship_shooter #(.COOL_TICKS(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .timer_tick(timer_tick), .btn_aim(btn_aim), .btn_fire(btn_fire),
    .monster_present(monster_present), .monster_ctrl(ctrl_b), .aim_dir(aim_b),
    .heat(heat_b), .kills(kills_b), .q_Idle(ib), .q_Ready(rb), .q_Kill(kb),
    .q_Cool(cb), .q_Lock(lb)
  );

  typedef struct packed {
    logic [4:0] st;
    logic [3:0] ctrl;
    logic [1:0] aim;
    logic [3:0] heat;
    logic [7:0] kills;
  } obs_t;

  typedef struct {
    logic       play, go, tick, fire;
    logic [3:0] aim, pres;
    obs_t       exp;
  } vec_t;

  int   tests = 0, fails = 0;
  obs_t exp_q[$];
  vec_t tbl[27];

  function automatic obs_t observe(input bit b);
    obs_t o;
    if (!b) begin
      o.st = {la, ca, ka, ra, ia}; o.ctrl = ctrl_a; o.aim = aim_a;
      o.heat = heat_a; o.kills = kills_a;
    end else begin
      o.st = {lb, cb, kb, rb, ib}; o.ctrl = ctrl_b; o.aim = aim_b;
      o.heat = heat_b; o.kills = kills_b;
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic p, g, t, f, input logic [3:0] a, pr,
                              input logic [4:0] st, input logic [3:0] c,
                              input logic [1:0] ad, input logic [3:0] h,
                              input logic [7:0] k);
    vec_t v;
    v.play = p; v.go = g; v.tick = t; v.fire = f; v.aim = a; v.pres = pr;
    v.exp.st = st; v.exp.ctrl = c; v.exp.aim = ad; v.exp.heat = h; v.exp.kills = k;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".state"}, 32'(a.st), 32'(e.st));
    chk({tag, ".ctrl"},  32'(a.ctrl), 32'(e.ctrl));
    chk({tag, ".aim"},   32'(a.aim), 32'(e.aim));
    chk({tag, ".heat"},  32'(a.heat), 32'(e.heat));
    chk({tag, ".kills"}, 32'(a.kills), 32'(e.kills));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare once the edge has landed
  task automatic apply(input bit b, input vec_t v, input string tag);
    obs_t e;
    play_flag = v.play; game_over = v.go; timer_tick = v.tick; btn_fire = v.fire;
    btn_aim = v.aim; monster_present = v.pres;
    exp_q.push_back(v.exp);
    @(posedge Clk); #1;
    timer_tick = 1'b0; btn_fire = 1'b0; btn_aim = '0;
    e = exp_q.pop_front();
    cmp_obs(tag, observe(b), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rst_exp;
    rst_exp = '{st: ST_I, ctrl: 4'h0, aim: 2'd0, heat: 4'd0, kills: 8'd0};

    tbl[0]  = mk(1,0,0,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1,0,0,0, 4'b0010, 4'b0000, ST_R, 4'b0000, 1, 0, 0);
    tbl[2]  = mk(1,0,0,1, 4'b0000, 4'b0010, ST_K, 4'b0010, 1, 4, 0);
    tbl[3]  = mk(1,0,0,0, 4'b0000, 4'b0010, ST_K, 4'b0010, 1, 4, 0);
    tbl[4]  = mk(1,0,0,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 4, 1);
    tbl[5]  = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 3, 1);
    tbl[6]  = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 2, 1);
    tbl[7]  = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 1, 1);
    tbl[8]  = mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 1, 0, 1);
    tbl[9]  = mk(1,0,0,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 4, 1);
    tbl[10] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 3, 1);
    tbl[11] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 2, 1);
    tbl[12] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 1, 1, 1);
    tbl[13] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 1, 0, 1);
    tbl[14] = mk(1,0,0,0, 4'b0001, 4'b0000, ST_R, 4'b0000, 0, 0, 1);
    tbl[15] = mk(1,0,0,1, 4'b1100, 4'b0001, ST_K, 4'b0001, 2, 4, 1);
    tbl[16] = mk(1,0,0,0, 4'b1000, 4'b0001, ST_K, 4'b0001, 3, 4, 1);
    tbl[17] = mk(1,0,0,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 3, 4, 2);
    tbl[18] = mk(1,1,0,0, 4'b0000, 4'b0000, ST_I, 4'b0000, 3, 4, 2);
    tbl[19] = mk(0,0,0,0, 4'b0010, 4'b0000, ST_I, 4'b0000, 3, 4, 2);
    tbl[20] = mk(1,0,0,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 3, 0, 0);
    tbl[21] = mk(1,0,0,0, 4'b0001, 4'b0000, ST_R, 4'b0000, 0, 0, 0);
    tbl[22] = mk(1,0,1,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 3, 0);
    tbl[23] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 2, 0);
    tbl[24] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 1, 0);
    tbl[25] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 0, 0);
    tbl[26] = mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 0, 0);

    repeat (2) @(posedge Clk);
    #1;
    cmp_obs("reset_a", observe(0), rst_exp);
    cmp_obs("reset_b", observe(1), rst_exp);
    Reset = 1'b1;

    for (int i = 0; i < 27; i++) apply(0, tbl[i], $sformatf("vec%0d", i));

    // Kill request held for the full timeout, no credit
    apply(0, mk(1,0,0,1, 4'b0000, 4'b0001, ST_K, 4'b0001, 0, 4, 0), "to_fire");
    for (int k = 1; k <= 64; k++)
      apply(0, mk(1,0,0,0, 4'b0000, 4'b0001, (k < 64) ? ST_K : ST_C,
                  (k < 64) ? 4'b0001 : 4'b0000, 0, 4, 0), $sformatf("to_cyc%0d", k));
    for (int k = 1; k <= 4; k++)
      apply(0, mk(1,0,1,0, 4'b0000, 4'b0000, (k < 4) ? ST_C : ST_R, 4'b0000, 0,
                  4'(4 - k), 0), $sformatf("to_cool%0d", k));

    // Ack arriving on the timeout cycle is credited
    apply(0, mk(1,0,0,1, 4'b0000, 4'b0001, ST_K, 4'b0001, 0, 4, 0), "ack_fire");
    for (int k = 1; k <= 64; k++)
      apply(0, mk(1,0,0,0, 4'b0000, (k < 64) ? 4'b0001 : 4'b0000, (k < 64) ? ST_K : ST_C,
                  (k < 64) ? 4'b0001 : 4'b0000, 0, 4, (k < 64) ? 8'd0 : 8'd1),
            $sformatf("ack_cyc%0d", k));
    for (int k = 1; k <= 4; k++)
      apply(0, mk(1,0,1,0, 4'b0000, 4'b0000, (k < 4) ? ST_C : ST_R, 4'b0000, 0,
                  4'(4 - k), 1), $sformatf("ack_cool%0d", k));

    // Reset asserted mid-KILL on the bottom slot
    apply(0, mk(1,0,0,0, 4'b0010, 4'b0000, ST_R, 4'b0000, 1, 0, 1), "rk_aim");
    apply(0, mk(1,0,0,1, 4'b0000, 4'b0010, ST_K, 4'b0010, 1, 4, 1), "rk_fire");
    monster_present = 4'b0010;
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    cmp_obs("rk_reset", observe(0), rst_exp);
    Reset = 1'b1;
    monster_present = '0;

    // Heat accumulation, exact-ceiling shot, lockout and decay back to READY
    apply(1, mk(1,0,0,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 0, 0), "lk_play");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 4, 0), "lk_f1");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 3, 0), "lk_t1");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 7, 0), "lk_f2");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 6, 0), "lk_t2");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 10, 0), "lk_f3");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 9, 0), "lk_t3");
    apply(1, mk(1,0,1,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 12, 0), "lk_f4tick");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 11, 0), "lk_t4");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_C, 4'b0000, 0, 15, 0), "lk_ceiling");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 14, 0), "lk_t5");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_L, 4'b0000, 0, 14, 0), "lk_lock");
    apply(1, mk(1,0,0,1, 4'b0000, 4'b0000, ST_L, 4'b0000, 0, 14, 0), "lk_fire_ign");
    for (int k = 1; k <= 14; k++)
      apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_L, 4'b0000, 0, 4'(14 - k), 0),
            $sformatf("lk_decay%0d", k));
    apply(1, mk(1,0,0,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 0, 0), "lk_ready");
    apply(1, mk(1,0,1,0, 4'b0000, 4'b0000, ST_R, 4'b0000, 0, 0, 0), "lk_floor");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
